mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1, meaning 1 = FETCH/MEMRD/MEMWR wait for mem_ready, 0 = fixed one cycle per state and mem_ready ignored.
REQ-002 Parameter CNT_W, default 32, meaning width of the retired-instruction counter.
REQ-003 Ports: clk in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-004 Inputs: op in 6 instr[31:26]; funct in 6 instr[5:0]; zero in 1 ALU result == 0; mem_ready in 1 memory access completes this cycle.
REQ-005 Memory and register outputs: mem_req out 1; iord out 1; memwrite out 1; irwrite out 1; regdst out 1; memtoreg out 1; regwrite out 1.
REQ-006 ALU and PC outputs: alusrca out 1; alusrcb out 2; alucontrol out 3; pcsrc out 2; pcen out 1.
REQ-007 Status outputs: state out 4 (debug); illegal out 1 (one-cycle pulse); retired out CNT_W.

Function
REQ-008 The block SHALL be a Moore FSM: all outputs except pcen SHALL decode from the state register only; pcen = pcwrite | (branch & zero).
REQ-009 The block SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; encodings 12-15 SHALL go to FETCH on the next clock.
REQ-010 State transitions SHALL be:
- FETCH->DECODE.
- DECODE on op: lw/sw (100011/101011)->MEMADR; R-type (000000)->EXECUTE; beq (000100)->BRANCH; addi (001000)->ADDIEX; j (000010)->JUMP; any other op->FETCH.
- MEMADR: lw->MEMRD, sw->MEMWR.
- MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-011 With MEM_WAIT_EN=1, FETCH, MEMRD and MEMWR SHALL hold until a cycle with mem_ready=1, then advance.
REQ-012 mem_req SHALL be 1 in FETCH, MEMRD and MEMWR, and 0 in all other states.
REQ-013 FETCH SHALL drive iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=1 and pcwrite=1 only in the completing cycle (mem_ready=1, or every cycle if MEM_WAIT_EN=0).
REQ-014 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=00.
REQ-015 MEMADR and ADDIEX SHALL drive alusrca=1, alusrcb=10, aluop=00.
REQ-016 Memory states:
- MEMRD: iord=1.
- MEMWR: iord=1, memwrite=1 for every cycle in the state.
- MEMWB: regdst=0, memtoreg=1, regwrite=1.
REQ-017 EXECUTE SHALL drive alusrca=1, alusrcb=00, aluop=10; ALUWB SHALL drive regdst=1, memtoreg=0, regwrite=1.
REQ-018 ADDIWB SHALL drive regdst=0, memtoreg=0, regwrite=1.
REQ-019 BRANCH SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; JUMP SHALL drive pcsrc=10, pcwrite=1.
REQ-020 Any output not listed for a state SHALL be 0.
REQ-021 alucontrol SHALL decode as:
- aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
- aluop 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct->010.
REQ-022 illegal SHALL pulse high for exactly one cycle on leaving DECODE with an unknown op, or leaving EXECUTE with an unknown funct.
REQ-023 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP, SHALL wrap modulo 2^CNT_W, and SHALL NOT increment on illegal-op aborts.

Reset
REQ-024 Asserting reset SHALL immediately force state=FETCH, retired=0 and illegal=0, including mid-instruction or mid-wait.
REQ-025 While reset is high, mem_req, irwrite, pcwrite, pcen, memwrite and regwrite SHALL be forced to 0.
REQ-026 After reset deasserts, the first clock edge SHALL be treated as FETCH.

Structure
REQ-027 A shared package SHALL hold the state encodings, opcode and funct constants, and the aluop and alucontrol codes.
REQ-028 ALU control decode SHALL be the sub-module mc_aludec (inputs funct and aluop; output alucontrol).

Verification
REQ-029 lw with MEM_WAIT_EN=0: op=100011 -> states 0,1,2,3,4,0; regwrite=1 only in state 4; retired 0->1.
REQ-030 sw with mem_ready low for 3 cycles in MEMWR: memwrite=1 for 4 cycles, then FETCH; retired increments once.
REQ-031 beq: zero=1 -> pcen=1 in BRANCH; zero=0 -> pcen=0 in BRANCH; pcsrc=01 in both cases.
REQ-032 op=111111 -> DECODE->FETCH, illegal high one cycle, retired unchanged; funct=000000 R-type -> alucontrol=010, illegal pulse.
REQ-033 reset asserted in MEMRD between clock edges -> state=0 at once, all write enables 0; after release, FETCH waits on mem_ready.
REQ-034 CNT_W=4, 17 j instructions -> retired wraps 15->0 and ends at 1.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared constants for the multicycle MIPS-style controller:
// state encodings, opcode/funct values and ALU control codes.
package mc_controller_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // True for R-type funct codes the datapath implements.
    function automatic logic funct_known(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
               (f == F_OR)  || (f == F_SLT);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU control decoder: maps aluop plus the R-type funct field
// onto the 3-bit ALU operation select.
module mc_aludec
    import mc_controller_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    // Unknown funct codes fall back to add so the ALU stays benign.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller: Moore FSM with optional memory wait,
// illegal-instruction pulse and retired-instruction counter.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alucontrol,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             mem_done;
    logic             retire;
    logic             pcwrite;
    logic             branch;
    logic [1:0]       aluop;

    // With waits disabled every memory state completes in one cycle.
    assign mem_done = !MEM_WAIT_EN || mem_ready;

    // Next state, illegal detection and retirement bookkeeping.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        retire    = 1'b0;
        unique case (state_q)
            S_FETCH: if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_done) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_done) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECUTE: begin
                state_d   = S_ALUWB;
                illegal_d = !funct_known(funct);
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    // State, pulse and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Control decode from state; reset masks every side effect.
    always_comb begin
        mem_req  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = ALUOP_ADD;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_done;
                pcwrite = mem_done;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            mem_req  = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
        pcen = pcwrite | (branch & zero);
    end

    mc_aludec u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a per-cycle vector table for
// the waiting controller plus hand sequences for reset and wrap.
module tb_mc_controller;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;
    localparam logic [5:0] FSUB = 6'b100010;
    localparam logic [5:0] FAND = 6'b100100;
    localparam logic [5:0] FOR  = 6'b100101;
    localparam logic [5:0] FSLT = 6'b101010;
    localparam logic [5:0] FNUL = 6'b000000;

    // {mem_req,iord,memwrite,irwrite,regdst,memtoreg,regwrite,
    //  alusrca,alusrcb[2],alucontrol[3],pcsrc[2],pcen}
    localparam logic [15:0] C_FW   = 16'b1_0_0_0_0_0_0_0_01_010_00_0;
    localparam logic [15:0] C_FR   = 16'b1_0_0_1_0_0_0_0_01_010_00_1;
    localparam logic [15:0] C_RST  = 16'b0_0_0_0_0_0_0_0_01_010_00_0;
    localparam logic [15:0] C_DEC  = 16'b0_0_0_0_0_0_0_0_11_010_00_0;
    localparam logic [15:0] C_MADR = 16'b0_0_0_0_0_0_0_1_10_010_00_0;
    localparam logic [15:0] C_MRD  = 16'b1_1_0_0_0_0_0_0_00_010_00_0;
    localparam logic [15:0] C_MWB  = 16'b0_0_0_0_0_1_1_0_00_010_00_0;
    localparam logic [15:0] C_MWR  = 16'b1_1_1_0_0_0_0_0_00_010_00_0;
    localparam logic [15:0] C_EXA  = 16'b0_0_0_0_0_0_0_1_00_010_00_0;
    localparam logic [15:0] C_EXS  = 16'b0_0_0_0_0_0_0_1_00_110_00_0;
    localparam logic [15:0] C_EXN  = 16'b0_0_0_0_0_0_0_1_00_000_00_0;
    localparam logic [15:0] C_EXO  = 16'b0_0_0_0_0_0_0_1_00_001_00_0;
    localparam logic [15:0] C_EXT  = 16'b0_0_0_0_0_0_0_1_00_111_00_0;
    localparam logic [15:0] C_AWB  = 16'b0_0_0_0_1_0_1_0_00_010_00_0;
    localparam logic [15:0] C_BR1  = 16'b0_0_0_0_0_0_0_1_00_110_01_1;
    localparam logic [15:0] C_BR0  = 16'b0_0_0_0_0_0_0_1_00_110_01_0;
    localparam logic [15:0] C_IWB  = 16'b0_0_0_0_0_0_1_0_00_010_00_0;
    localparam logic [15:0] C_JMP  = 16'b0_0_0_0_0_0_0_0_00_010_10_1;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        ill;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[$];
    int   nvec  = 0;
    int   nfail = 0;

    logic clk = 1'b0;
    logic reset;

    logic [5:0]  op_a, funct_a;
    logic        zero_a, rdy_a;
    logic        mem_req_a, iord_a, memwrite_a, irwrite_a;
    logic        regdst_a, memtoreg_a, regwrite_a, alusrca_a;
    logic [1:0]  alusrcb_a, pcsrc_a;
    logic [2:0]  alucontrol_a;
    logic        pcen_a, illegal_a;
    logic [3:0]  state_a;
    logic [31:0] retired_a;
    logic [15:0] ctrl_a;

    logic [5:0]  op_b, funct_b;
    logic        zero_b, rdy_b;
    logic        mem_req_b, iord_b, memwrite_b, irwrite_b;
    logic        regdst_b, memtoreg_b, regwrite_b, alusrca_b;
    logic [1:0]  alusrcb_b, pcsrc_b;
    logic [2:0]  alucontrol_b;
    logic        pcen_b, illegal_b;
    logic [3:0]  state_b;
    logic [3:0]  retired_b;
    logic [15:0] ctrl_b;

    always #5 clk = ~clk;

    assign ctrl_a = {mem_req_a, iord_a, memwrite_a, irwrite_a,
                     regdst_a, memtoreg_a, regwrite_a, alusrca_a,
                     alusrcb_a, alucontrol_a, pcsrc_a, pcen_a};
    assign ctrl_b = {mem_req_b, iord_b, memwrite_b, irwrite_b,
                     regdst_b, memtoreg_b, regwrite_b, alusrca_b,
                     alusrcb_b, alucontrol_b, pcsrc_b, pcen_b};

    mc_controller #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .op(op_a), .funct(funct_a), .zero(zero_a), .mem_ready(rdy_a),
        .mem_req(mem_req_a), .iord(iord_a), .memwrite(memwrite_a),
        .irwrite(irwrite_a), .regdst(regdst_a), .memtoreg(memtoreg_a),
        .regwrite(regwrite_a), .alusrca(alusrca_a), .alusrcb(alusrcb_a),
        .alucontrol(alucontrol_a), .pcsrc(pcsrc_a), .pcen(pcen_a),
        .state(state_a), .illegal(illegal_a), .retired(retired_a)
    );

    mc_controller #(.MEM_WAIT_EN(1'b0), .CNT_W(4)) dutb (
        .clk(clk), .reset(reset),
        .op(op_b), .funct(funct_b), .zero(zero_b), .mem_ready(rdy_b),
        .mem_req(mem_req_b), .iord(iord_b), .memwrite(memwrite_b),
        .irwrite(irwrite_b), .regdst(regdst_b), .memtoreg(memtoreg_b),
        .regwrite(regwrite_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b),
        .alucontrol(alucontrol_b), .pcsrc(pcsrc_b), .pcen(pcen_b),
        .state(state_b), .illegal(illegal_b), .retired(retired_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic r, input logic [3:0] st,
                       input logic [15:0] c, input logic il,
                       input logic [31:0] rt);
        vec_t v;
        v.op = op; v.funct = fn; v.zero = z; v.rdy = r;
        v.st = st; v.ctrl = c; v.ill = il; v.ret = rt;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_st [6] = '{0, 1, 2, 3, 4, 0};
        int exp_rw [6] = '{0, 0, 0, 0, 1, 0};
        int exp_rt [6] = '{0, 0, 0, 0, 0, 1};

        // lw, waits once in FETCH-ready path and once in MEMRD
        add(LW, FNUL, 0, 0, 0, C_FW, 0, 0);
        add(LW, FNUL, 0, 1, 0, C_FR, 0, 0);
        add(LW, FNUL, 0, 0, 1, C_DEC, 0, 0);
        add(LW, FNUL, 0, 0, 2, C_MADR, 0, 0);
        add(LW, FNUL, 0, 0, 3, C_MRD, 0, 0);
        add(LW, FNUL, 0, 1, 3, C_MRD, 0, 0);
        add(LW, FNUL, 0, 0, 4, C_MWB, 0, 0);
        // R-type sub
        add(RT, FSUB, 0, 1, 0, C_FR, 0, 1);
        add(RT, FSUB, 0, 0, 1, C_DEC, 0, 1);
        add(RT, FSUB, 0, 0, 6, C_EXS, 0, 1);
        add(RT, FSUB, 0, 0, 7, C_AWB, 0, 1);
        // beq taken
        add(BEQ, FNUL, 1, 1, 0, C_FR, 0, 2);
        add(BEQ, FNUL, 1, 0, 1, C_DEC, 0, 2);
        add(BEQ, FNUL, 1, 0, 8, C_BR1, 0, 2);
        // addi
        add(ADDI, FNUL, 0, 1, 0, C_FR, 0, 3);
        add(ADDI, FNUL, 0, 0, 1, C_DEC, 0, 3);
        add(ADDI, FNUL, 0, 0, 9, C_MADR, 0, 3);
        add(ADDI, FNUL, 0, 0, 10, C_IWB, 0, 3);
        // sw with three wait cycles in MEMWR
        add(SW, FNUL, 0, 1, 0, C_FR, 0, 4);
        add(SW, FNUL, 0, 0, 1, C_DEC, 0, 4);
        add(SW, FNUL, 0, 0, 2, C_MADR, 0, 4);
        add(SW, FNUL, 0, 0, 5, C_MWR, 0, 4);
        add(SW, FNUL, 0, 0, 5, C_MWR, 0, 4);
        add(SW, FNUL, 0, 0, 5, C_MWR, 0, 4);
        add(SW, FNUL, 0, 1, 5, C_MWR, 0, 4);
        // beq not taken
        add(BEQ, FNUL, 0, 1, 0, C_FR, 0, 5);
        add(BEQ, FNUL, 0, 0, 1, C_DEC, 0, 5);
        add(BEQ, FNUL, 0, 0, 8, C_BR0, 0, 5);
        // illegal op, then R-type with unknown funct
        add(BAD, FNUL, 0, 1, 0, C_FR, 0, 6);
        add(BAD, FNUL, 0, 0, 1, C_DEC, 0, 6);
        add(RT, FNUL, 0, 1, 0, C_FR, 1, 6);
        add(RT, FNUL, 0, 0, 1, C_DEC, 0, 6);
        add(RT, FNUL, 0, 0, 6, C_EXA, 0, 6);
        add(RT, FNUL, 0, 0, 7, C_AWB, 1, 6);
        // and, or, slt
        add(RT, FAND, 0, 1, 0, C_FR, 0, 7);
        add(RT, FAND, 0, 0, 1, C_DEC, 0, 7);
        add(RT, FAND, 0, 0, 6, C_EXN, 0, 7);
        add(RT, FAND, 0, 0, 7, C_AWB, 0, 7);
        add(RT, FOR, 0, 1, 0, C_FR, 0, 8);
        add(RT, FOR, 0, 0, 1, C_DEC, 0, 8);
        add(RT, FOR, 0, 0, 6, C_EXO, 0, 8);
        add(RT, FOR, 0, 0, 7, C_AWB, 0, 8);
        add(RT, FSLT, 0, 1, 0, C_FR, 0, 9);
        add(RT, FSLT, 0, 0, 1, C_DEC, 0, 9);
        add(RT, FSLT, 0, 0, 6, C_EXT, 0, 9);
        add(RT, FSLT, 0, 0, 7, C_AWB, 0, 9);
        // jump
        add(JMP, FNUL, 0, 0, 0, C_FW, 0, 10);
        add(JMP, FNUL, 0, 1, 0, C_FR, 0, 10);
        add(JMP, FNUL, 0, 0, 1, C_DEC, 0, 10);
        add(JMP, FNUL, 0, 0, 11, C_JMP, 0, 10);
        add(JMP, FNUL, 0, 0, 0, C_FW, 0, 11);

        reset = 1'b1;
        op_a = RT; funct_a = FNUL; zero_a = 1'b0; rdy_a = 1'b1;
        op_b = JMP; funct_b = FNUL; zero_b = 1'b0; rdy_b = 1'b0;
        #2;
        chk("reset state", 32'(state_a), 32'd0);
        chk("reset ctrl", 32'(ctrl_a), 32'(C_RST));
        chk("reset illegal", 32'(illegal_a), 32'd0);
        chk("reset retired", retired_a, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        foreach (tbl[i]) begin
            op_a = tbl[i].op; funct_a = tbl[i].funct;
            zero_a = tbl[i].zero; rdy_a = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d state", i), 32'(state_a), 32'(tbl[i].st));
            chk($sformatf("row%0d ctrl", i), 32'(ctrl_a), 32'(tbl[i].ctrl));
            chk($sformatf("row%0d illegal", i), 32'(illegal_a), 32'(tbl[i].ill));
            chk($sformatf("row%0d retired", i), retired_a, tbl[i].ret);
            @(negedge clk);
        end

        // reset mid-MEMRD, then FETCH must wait again
        op_a = LW; rdy_a = 1'b1;
        step();
        rdy_a = 1'b0;
        step();
        step();
        chk("pre-reset memrd", 32'(state_a), 32'd3);
        rdy_a = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async reset state", 32'(state_a), 32'd0);
        chk("async reset ctrl", 32'(ctrl_a), 32'(C_RST));
        chk("async reset retired", retired_a, 32'd0);
        chk("async reset illegal", 32'(illegal_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rdy_a = 1'b0;
        #1 chk("post-reset wait ctrl", 32'(ctrl_a), 32'(C_FW));
        step();
        chk("post-reset holds", 32'(state_a), 32'd0);
        rdy_a = 1'b1;
        #1 chk("post-reset ready ctrl", 32'(ctrl_a), 32'(C_FR));
        step();
        chk("post-reset decode", 32'(state_a), 32'd1);

        // no-wait lw: mem_ready ignored
        reset = 1'b1;
        op_b = LW; rdy_b = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("nowait st%0d", k), 32'(state_b), 32'(exp_st[k]));
            chk($sformatf("nowait rw%0d", k), 32'(regwrite_b), 32'(exp_rw[k]));
            chk($sformatf("nowait ret%0d", k), 32'(retired_b), 32'(exp_rt[k]));
            if (k == 0)
                chk("nowait irwrite", 32'(irwrite_b), 32'd1);
            @(negedge clk);
        end

        // 17 jumps on a 4-bit counter
        reset = 1'b1;
        op_b = JMP;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            step();
            step();
            #1 chk($sformatf("jump%0d pcen", n), 32'(pcen_b), 32'd1);
            @(negedge clk);
            chk($sformatf("jump%0d state", n), 32'(state_b), 32'd0);
            chk($sformatf("jump%0d retired", n), 32'(retired_b), 32'(n % 16));
        end
        chk("wrap final", 32'(retired_b), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
